// File: rtl/pli_monitor_pkg.sv
// Shared types for the PLI-style run-time monitor: failure source codes,
// req/ack checker states and a population-count helper.
package pli_monitor_pkg;

  localparam int POP_MAX_W = 256;

  typedef enum logic [2:0] {
    FC_NONE   = 3'd0,
    FC_USER   = 3'd1,
    FC_ASSERT = 3'd2,
    FC_AMONE  = 3'd3,
    FC_ONEHOT = 3'd4,
    FC_REQACK = 3'd5
  } fail_code_e;

  typedef enum logic {
    RA_IDLE = 1'b0,
    RA_WAIT = 1'b1
  } ra_state_e;

  // Callers zero-extend their vector to POP_MAX_W bits.
  function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [8:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + 9'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pli_monitor_reqack.sv
// Request/grant handshake checker: flags stray acks, overlapping requests
// and requests that go unanswered for ACK_TIMEOUT cycles.
module pli_reqack_checker
  import pli_monitor_pkg::*;
#(
  parameter int ACK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic fail_o
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  ra_state_e       state_q;
  logic [CW-1:0]   cnt_q;

  // Failure is decoded from the current state so the monitor can count it
  // on the same edge as every other source.
  assign fail_o = (state_q == RA_IDLE) ? ack
                : (!ack && (req || (cnt_q == CNT_LAST)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RA_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RA_IDLE: begin
          if (req && !ack) begin
            state_q <= RA_WAIT;
            cnt_q   <= '0;
          end
        end
        RA_WAIT: begin
          if (ack) begin
            state_q <= RA_IDLE;
            cnt_q   <= '0;
          end else if (req) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= RA_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RA_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pli_monitor.sv
// Run-time protocol monitor with info filtering, saturating warn/error counts
// and a sticky stop request. Define PLI_MONITOR_REQACK_EN to add the req/ack checker.
module pli_monitor
  import pli_monitor_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ACK_TIMEOUT = 8,
  parameter int MAX_ERRORS  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       debug_level,
  input  logic             info_valid,
  input  logic [3:0]       info_level,
  input  logic             assert_valid,
  input  logic             assert_cond,
  input  logic             amone_valid,
  input  logic [WIDTH-1:0] amone_vec,
  input  logic             onehot_valid,
  input  logic [WIDTH-1:0] onehot_vec,
  input  logic             req,
  input  logic             ack,
  input  logic             warn_valid,
  input  logic             error_valid,
  output logic             info_print,
  output logic [CNT_W-1:0] warn_count,
  output logic [CNT_W-1:0] error_count,
  output logic             error_flag,
  output logic [2:0]       fail_code,
  output logic             stop
);

  localparam int SW = ((CNT_W > 3) ? CNT_W : 3) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       inc);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(inc);
    return (s > SW'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  logic             info_print_q, info_print_d;
  logic [CNT_W-1:0] warn_q, warn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             error_flag_q, error_flag_d;
  fail_code_e       fc_q, fc_d;
  logic             stop_q, stop_d;

  logic user_fail, assert_fail, amone_fail, onehot_fail, reqack_fail;
  logic [8:0] amone_pop, onehot_pop;
  logic [2:0] nfail;

  assign amone_pop  = popcount(POP_MAX_W'(amone_vec));
  assign onehot_pop = popcount(POP_MAX_W'(onehot_vec));

  assign user_fail   = error_valid;
  assign assert_fail = assert_valid && !assert_cond;
  assign amone_fail  = amone_valid && (amone_pop > 9'd1);
  assign onehot_fail = onehot_valid && (onehot_pop != 9'd1);

`ifdef PLI_MONITOR_REQACK_EN
  pli_reqack_checker #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_reqack (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .ack    (ack),
    .fail_o (reqack_fail)
  );
`else
  logic unused_reqack;
  assign unused_reqack = req ^ ack;
  assign reqack_fail   = 1'b0;
`endif

  assign nfail = 3'(user_fail) + 3'(assert_fail) + 3'(amone_fail)
               + 3'(onehot_fail) + 3'(reqack_fail);

  always_comb begin
    info_print_d = info_valid && (info_level <= debug_level);
    warn_d       = warn_q;
    err_d        = err_q;
    fc_d         = fc_q;
    error_flag_d = error_flag_q || (nfail != 3'd0);
    // Compare in a widened domain so small CNT_W never truncates MAX_ERRORS.
    stop_d       = stop_q || ((CNT_W + 32)'(err_q) >= (CNT_W + 32)'(MAX_ERRORS));
    if (!stop_q) begin
      warn_d = sat_add(warn_q, {2'b00, warn_valid});
      err_d  = sat_add(err_q, nfail);
      if (user_fail)        fc_d = FC_USER;
      else if (assert_fail) fc_d = FC_ASSERT;
      else if (amone_fail)  fc_d = FC_AMONE;
      else if (onehot_fail) fc_d = FC_ONEHOT;
      else if (reqack_fail) fc_d = FC_REQACK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      info_print_q <= 1'b0;
      warn_q       <= '0;
      err_q        <= '0;
      error_flag_q <= 1'b0;
      fc_q         <= FC_NONE;
      stop_q       <= 1'b0;
    end else begin
      info_print_q <= info_print_d;
      warn_q       <= warn_d;
      err_q        <= err_d;
      error_flag_q <= error_flag_d;
      fc_q         <= fc_d;
      stop_q       <= stop_d;
    end
  end

  assign info_print  = info_print_q;
  assign warn_count  = warn_q;
  assign error_count = err_q;
  assign error_flag  = error_flag_q;
  assign fail_code   = fc_q;
  assign stop        = stop_q;

endmodule

// File: tb/tb_pli_monitor.sv
// Directed bench for pli_monitor: three instances (default, MAX_ERRORS=10,
// 2-bit counters) share one stimulus stream.
module tb_pli_monitor;

`ifdef PLI_MONITOR_REQACK_EN
  localparam int RA = 1;
`else
  localparam int RA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] debug_level, info_level;
  logic       info_valid, assert_valid, assert_cond;
  logic       amone_valid, onehot_valid, req, ack, warn_valid, error_valid;
  logic [7:0] amone_vec, onehot_vec;

  logic        a_info, a_flag, a_stop;
  logic [15:0] a_warn, a_err;
  logic [2:0]  a_fc;
  logic        b_info, b_flag, b_stop;
  logic [15:0] b_warn, b_err;
  logic [2:0]  b_fc;
  logic        c_info, c_flag, c_stop;
  logic [1:0]  c_warn, c_err;
  logic [2:0]  c_fc;

  int checks = 0;
  int errors = 0;
  int e10    = 0;

  always #5 clk = ~clk;

  pli_monitor dut (
    .clk(clk), .rst_n(rst_n), .debug_level(debug_level),
    .info_valid(info_valid), .info_level(info_level),
    .assert_valid(assert_valid), .assert_cond(assert_cond),
    .amone_valid(amone_valid), .amone_vec(amone_vec),
    .onehot_valid(onehot_valid), .onehot_vec(onehot_vec),
    .req(req), .ack(ack), .warn_valid(warn_valid), .error_valid(error_valid),
    .info_print(a_info), .warn_count(a_warn), .error_count(a_err),
    .error_flag(a_flag), .fail_code(a_fc), .stop(a_stop)
  );

  pli_monitor #(.MAX_ERRORS(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .debug_level(debug_level),
    .info_valid(info_valid), .info_level(info_level),
    .assert_valid(assert_valid), .assert_cond(assert_cond),
    .amone_valid(amone_valid), .amone_vec(amone_vec),
    .onehot_valid(onehot_valid), .onehot_vec(onehot_vec),
    .req(req), .ack(ack), .warn_valid(warn_valid), .error_valid(error_valid),
    .info_print(b_info), .warn_count(b_warn), .error_count(b_err),
    .error_flag(b_flag), .fail_code(b_fc), .stop(b_stop)
  );

  pli_monitor #(.MAX_ERRORS(10), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .debug_level(debug_level),
    .info_valid(info_valid), .info_level(info_level),
    .assert_valid(assert_valid), .assert_cond(assert_cond),
    .amone_valid(amone_valid), .amone_vec(amone_vec),
    .onehot_valid(onehot_valid), .onehot_vec(onehot_vec),
    .req(req), .ack(ack), .warn_valid(warn_valid), .error_valid(error_valid),
    .info_print(c_info), .warn_count(c_warn), .error_count(c_err),
    .error_flag(c_flag), .fail_code(c_fc), .stop(c_stop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    debug_level = 4'd0; info_valid = 1'b0; info_level = 4'd0;
    assert_valid = 1'b0; assert_cond = 1'b1;
    amone_valid = 1'b0; amone_vec = 8'd0;
    onehot_valid = 1'b0; onehot_vec = 8'd0;
    req = 1'b0; ack = 1'b0; warn_valid = 1'b0; error_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Activity during reset must be ignored.
    error_valid = 1'b1; warn_valid = 1'b1; info_valid = 1'b1;
    assert_valid = 1'b1; assert_cond = 1'b0;
    amone_valid = 1'b1; amone_vec = 8'b011; req = 1'b1; ack = 1'b1;
    step(); step();
    chk("rst_info", 32'(a_info), 0);
    chk("rst_warn", 32'(a_warn), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_flag", 32'(a_flag), 0);
    chk("rst_fc", 32'(a_fc), 0);
    chk("rst_stop", 32'(a_stop), 0);
    clear_inputs();
    rst_n = 1'b1;
    step();
    chk("post_rst_err", 32'(a_err), 0);

    // Info verbosity filter
    debug_level = 4'd1; info_valid = 1'b1;
    info_level = 4'd0; step(); chk("info_lvl0", 32'(a_info), 1);
    info_level = 4'd1; step(); chk("info_lvl1", 32'(a_info), 1);
    info_level = 4'd9; step(); chk("info_lvl9", 32'(a_info), 0);
    info_level = 4'd0; info_valid = 1'b0; step(); chk("info_novalid", 32'(a_info), 0);

    // At-most-one-hot
    amone_valid = 1'b1;
    amone_vec = 8'b100; step();
    amone_vec = 8'b010; step();
    amone_vec = 8'b001; step();
    amone_vec = 8'b000; step();
    chk("amone_pass_err", 32'(a_err), 0);
    chk("amone_pass_flag", 32'(a_flag), 0);
    amone_vec = 8'b011; step();
    amone_valid = 1'b0; amone_vec = 8'd0;
    chk("amone_err", 32'(a_err), 1);
    chk("amone_fc", 32'(a_fc), 3);
    chk("amone_flag", 32'(a_flag), 1);
    chk("amone_stop_early", 32'(a_stop), 0);
    step();
    chk("amone_stop", 32'(a_stop), 1);
    chk("dut10_amone_err", 32'(b_err), 1);

    // Exactly-one-hot; default instance is stopped and must stay frozen
    onehot_valid = 1'b1;
    onehot_vec = 8'b10; step();
    onehot_vec = 8'b01; step();
    chk("onehot_pass_err", 32'(b_err), 1);
    onehot_vec = 8'b00; step();
    onehot_valid = 1'b0;
    chk("onehot_err", 32'(b_err), 2);
    chk("onehot_fc", 32'(b_fc), 4);
    chk("frozen_err", 32'(a_err), 1);
    chk("frozen_fc", 32'(a_fc), 3);
    chk("stop_hold", 32'(a_stop), 1);

    // Reset clears a stopped monitor
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst2_stop", 32'(a_stop), 0);
    chk("rst2_err", 32'(a_err), 0);
    chk("rst2_fc", 32'(a_fc), 0);
    chk("rst2_flag", 32'(a_flag), 0);
    chk("rst2_warn", 32'(a_warn), 0);

    // Simultaneous assert + user failures
    assert_valid = 1'b1; assert_cond = 1'b0; error_valid = 1'b1; step();
    assert_valid = 1'b0; assert_cond = 1'b1; error_valid = 1'b0;
    chk("sim_err", 32'(b_err), 2);
    chk("sim_fc", 32'(b_fc), 1);
    chk("sat_err_2", 32'(c_err), 2);
    warn_valid = 1'b1; step(); warn_valid = 1'b0;
    chk("warn_one", 32'(b_warn), 1);
    chk("warn_err_same", 32'(b_err), 2);

    // Saturation on 2-bit counters
    assert_valid = 1'b1; assert_cond = 1'b0; error_valid = 1'b1; step();
    assert_valid = 1'b0; assert_cond = 1'b1; error_valid = 1'b0;
    chk("sat_err", 32'(c_err), 3);
    chk("sim_err2", 32'(b_err), 4);
    warn_valid = 1'b1; step(); step(); step(); warn_valid = 1'b0;
    chk("sat_warn", 32'(c_warn), 3);
    chk("warn_four", 32'(b_warn), 4);

    // Priority among simultaneous non-user failures, then hold
    assert_valid = 1'b1; assert_cond = 1'b0;
    amone_valid = 1'b1; amone_vec = 8'b11;
    onehot_valid = 1'b1; onehot_vec = 8'b00;
    step();
    assert_valid = 1'b0; assert_cond = 1'b1;
    chk("prio_err", 32'(b_err), 7);
    chk("prio_fc", 32'(b_fc), 2);
    onehot_valid = 1'b0;
    step();
    chk("prio2_err", 32'(b_err), 8);
    chk("prio2_fc", 32'(b_fc), 3);
    amone_valid = 1'b0; amone_vec = 8'd0;
    step();
    chk("fc_hold", 32'(b_fc), 3);
    onehot_valid = 1'b1; onehot_vec = 8'hFF; step();
    onehot_valid = 1'b0; onehot_vec = 8'd0;
    chk("onehot_ff_err", 32'(b_err), 9);
    error_valid = 1'b1; step(); error_valid = 1'b0;
    chk("max10_err", 32'(b_err), 10);
    chk("max10_stop_early", 32'(b_stop), 0);
    step();
    chk("max10_stop", 32'(b_stop), 1);

    // Request/acknowledge handshake
    rst_n = 1'b0; step(); rst_n = 1'b1;
    e10 = 0;
    req = 1'b1; step(); req = 1'b0; step(); ack = 1'b1; step(); ack = 1'b0;
    chk("hs_ok_err", 32'(b_err), 32'(e10));
    chk("hs_ok_fc", 32'(b_fc), 0);
    ack = 1'b1; step(); ack = 1'b0;
    e10 += RA;
    chk("stray_ack_err", 32'(b_err), 32'(e10));
    chk("stray_ack_fc", 32'(b_fc), 32'(RA * 5));
    req = 1'b1; step(); req = 1'b0;
    repeat (7) step();
    chk("timeout_early", 32'(b_err), 32'(e10));
    step();
    e10 += RA;
    chk("timeout_err", 32'(b_err), 32'(e10));
    chk("timeout_fc", 32'(b_fc), 32'(RA * 5));
    req = 1'b1; step(); req = 1'b0;
    repeat (7) step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("late_ack_ok", 32'(b_err), 32'(e10));
    req = 1'b1; ack = 1'b1; step(); req = 1'b0; ack = 1'b0;
    e10 += RA;
    chk("reqack_same", 32'(b_err), 32'(e10));
    ack = 1'b1; step(); ack = 1'b0;
    e10 += RA;
    chk("reqack_same_idle", 32'(b_err), 32'(e10));
    req = 1'b1; step(); step(); req = 1'b0;
    e10 += RA;
    chk("double_req", 32'(b_err), 32'(e10));
    ack = 1'b1; step(); ack = 1'b0;
    chk("double_req_ack", 32'(b_err), 32'(e10));

    // Reset mid-handshake abandons the request
    req = 1'b1; step(); req = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    step(); step();
    chk("midrst_err", 32'(b_err), 0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("midrst_ack", 32'(b_err), 32'(RA));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pli_monitor.md
PLI_MONITOR -- requirements
Module: pli_monitor

Interface
REQ-001 Parameter WIDTH, default 8: width of the at-most-one and one-hot check vectors.
REQ-002 Parameter ACK_TIMEOUT, default 8: maximum number of cycles from req to ack.
REQ-003 Parameter MAX_ERRORS, default 1: error count at which stop asserts.
REQ-004 Parameter CNT_W, default 16: width of the warning and error counters.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 debug_level  in  4  current message verbosity.
REQ-008 info_valid, info_level  in  1, 4  info message request and its level.
REQ-009 assert_valid, assert_cond  in  1, 1  generic assertion check.
REQ-010 amone_valid, amone_vec  in  1, WIDTH  at-most-one-hot check.
REQ-011 onehot_valid, onehot_vec  in  1, WIDTH  exactly-one-hot check.
REQ-012 req, ack  in  1, 1  request/grant handshake pair; each is a single-cycle pulse.
REQ-013 warn_valid, error_valid  in  1, 1  user warning and user error events.
REQ-014 info_print  out  1  a pending info message passed the verbosity filter.
REQ-015 warn_count, error_count  out  CNT_W, CNT_W  saturating event counts.
REQ-016 error_flag  out  1  sticky: at least one error has occurred.
REQ-017 fail_code  out  3  source of the most recent error.
REQ-018 stop  out  1  sticky: simulation/stop request.

Function
REQ-019 All outputs SHALL be registered; an input event sampled at edge N SHALL be reflected in the outputs after edge N.
REQ-020 info_print SHALL be 1 exactly when info_valid=1 and info_level <= debug_level (unsigned comparison).
REQ-021 An assert failure SHALL be assert_valid=1 with assert_cond=0.
REQ-022 An amone failure SHALL be amone_valid=1 with popcount(amone_vec) > 1; a vector of all zeros passes.
REQ-023 A onehot failure SHALL be onehot_valid=1 with popcount(onehot_vec) != 1.
REQ-024 The req/ack checker SHALL have two states, IDLE and WAIT.
- IDLE + req: go to WAIT and clear the wait counter.
- IDLE + ack without req: failure.
- IDLE + req and ack in the same cycle: failure, and stay in IDLE.
REQ-025 In WAIT:
- ack: return to IDLE with no failure.
- req: failure; stay in WAIT and restart the counter.
- counter reaches ACK_TIMEOUT with no ack: failure; go to IDLE.
REQ-026 error_valid SHALL count as a USER failure; warn_valid SHALL increment warn_count only.
REQ-027 error_count SHALL increase each cycle by the number of failing sources in that cycle, saturating at all-ones; warn_count SHALL saturate likewise.
REQ-028 fail_code values SHALL be NONE=0, USER=1, ASSERT=2, AMONE=3, ONEHOT=4, REQACK=5.
- When several sources fail in the same cycle, priority is USER > ASSERT > AMONE > ONEHOT > REQACK.
- fail_code holds its value until the next failure.
REQ-029 error_flag SHALL set on any failure and hold until reset.
REQ-030 stop SHALL assert on the cycle after error_count reaches MAX_ERRORS and hold until reset.
REQ-031 While stop=1, both counters and fail_code SHALL freeze.

Reset
REQ-032 While rst_n=0 at a clock edge, the following SHALL be cleared:
- info_print=0, warn_count=0, error_count=0
- error_flag=0, fail_code=NONE, stop=0
- checker state IDLE, wait counter 0
REQ-033 Reset mid-handshake SHALL abandon the outstanding request with no failure.
REQ-034 Inputs asserted during reset SHALL be ignored.

Configuration
REQ-035 With PLI_MONITOR_REQACK_EN defined, the req/ack checker SHALL be present.
REQ-036 Without PLI_MONITOR_REQACK_EN, req and ack SHALL be ignored and REQACK failures SHALL never occur; all other behaviour is unchanged.

Structure
REQ-037 Package pli_monitor_pkg SHALL hold the fail_code enum, the checker state enum and a popcount function.
REQ-038 The req/ack checker SHALL be the sub-module pli_reqack_checker, instantiated only under PLI_MONITOR_REQACK_EN.

Verification
REQ-039 Info filter: debug_level=1; info_level 0 -> info_print=1; info_level 1 -> info_print=1; info_level 9 -> info_print=0.
REQ-040 amone: amone_vec 8'b100, 8'b010, 8'b001, 8'b000 -> no errors; then 8'b011 -> error_count=1, fail_code=3, stop=1 on the following cycle.
REQ-041 onehot: onehot_vec 8'b10 and 8'b01 -> no error; 8'b00 -> error_count=1, fail_code=4.
REQ-042 Handshake:
- req at cycle 1, ack at cycle 3 -> no error.
- ack at cycle 5 without req -> fail_code=5.
- req with no ack for 8 cycles -> fail_code=5.
REQ-043 Simultaneous events: MAX_ERRORS=10; assert_cond=0 together with error_valid in one cycle -> error_count=2, fail_code=1; a warn_valid pulse -> warn_count=1.
REQ-044 Reset: stop=1, then rst_n=0 for 1 cycle -> all outputs 0 and the checker in IDLE.
